// File: rtl/sdram_arbiter_if.sv
// Requester-side and Avalon-MM-side bus of the SDRAM arbiter.
// The master modport is the arbiter's view. It drives the SDRAM command and
// the requester completion signals. The slave modport is the view of the
// surroundings: the requesting cores plus the SDRAM controller.
interface sdram_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 23,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_read;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_writedata;
  logic [DATA_W-1:0]         req_readdata;
  logic [NUM_REQ-1:0]        req_finished;
  logic [ADDR_W-1:0]         avm_address;
  logic                      avm_read;
  logic                      avm_write;
  logic [DATA_W-1:0]         avm_writedata;
  logic [DATA_W-1:0]         avm_readdata;
  logic                      avm_waitrequest;
  logic                      avm_readdatavalid;
  logic [NUM_REQ-1:0]        grant;
  logic                      timeout_err;

  modport master (
    input  req_read, req_write, req_addr, req_writedata,
    input  avm_readdata, avm_waitrequest, avm_readdatavalid,
    output req_readdata, req_finished,
    output avm_address, avm_read, avm_write, avm_writedata,
    output grant, timeout_err
  );

  modport slave (
    output req_read, req_write, req_addr, req_writedata,
    output avm_readdata, avm_waitrequest, avm_readdatavalid,
    input  req_readdata, req_finished,
    input  avm_address, avm_read, avm_write, avm_writedata,
    input  grant, timeout_err
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter that shares one Avalon-MM SDRAM port between several
// read/write/finished requesters. Only one transaction is in flight at a time.
// There is always one IDLE cycle between transactions, so each requester can
// drop its request after finished before the next grant decision.
module sdram_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 23,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic            i_clk,
  input  logic            i_rst,
  sdram_arbiter_if.master bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ_CMD,
    ST_READ_WAIT
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [IDX_W-1:0]    r_gnt_idx;
  logic [IDX_W-1:0]    r_last_idx;
  logic [ADDR_W-1:0]   r_op_addr;
  logic [DATA_W-1:0]   r_op_data;
  logic [TMO_W-1:0]    r_tmo_cnt;
  logic                r_timeout_err;

  logic [NUM_REQ-1:0]  w_pending;
  logic [ADDR_W-1:0]   w_addr [NUM_REQ];
  logic [DATA_W-1:0]   w_data [NUM_REQ];
  logic                w_win_valid;
  logic [IDX_W-1:0]    w_win_idx;
  logic [IDX_W:0]      w_cand;
  logic [NUM_REQ-1:0]  w_gnt_onehot;
  logic                w_tmo_hit;

  assign w_pending    = bus.req_read | bus.req_write;
  assign w_gnt_onehot = NUM_REQ'(1) << r_gnt_idx;
  assign w_tmo_hit    = (r_tmo_cnt == TMO_W'(TIMEOUT));
  assign bus.timeout_err = r_timeout_err;

  // Unpack the flattened per-requester operand buses.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_addr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
      assign w_data[gi] = bus.req_writedata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Round-robin search: first pending requester after the last winner, wrapping.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_idx   = '0;
    w_cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = {1'b0, r_last_idx} + (IDX_W+1)'(k);
      if (w_cand >= (IDX_W+1)'(NUM_REQ)) begin
        w_cand = w_cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!w_win_valid && w_pending[w_cand[IDX_W-1:0]]) begin
        w_win_valid = 1'b1;
        w_win_idx   = w_cand[IDX_W-1:0];
      end
    end
  end

  // State register plus the operand, timeout and ownership registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_gnt_idx     <= '0;
      r_last_idx    <= IDX_W'(NUM_REQ - 1);
      r_op_addr     <= '0;
      r_op_data     <= '0;
      r_tmo_cnt     <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (w_win_valid) begin
            r_gnt_idx  <= w_win_idx;
            r_last_idx <= w_win_idx;
            r_op_addr  <= w_addr[w_win_idx];
            r_op_data  <= w_data[w_win_idx];
          end
        end
        ST_READ_CMD: begin
          if (!bus.avm_waitrequest) begin
            r_tmo_cnt <= '0;
          end
        end
        ST_READ_WAIT: begin
          if (!bus.avm_readdatavalid) begin
            if (w_tmo_hit) begin
              r_timeout_err <= 1'b1;
            end else begin
              r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Next state plus all bus outputs. Everything is held at zero in IDLE.
  always_comb begin
    w_state_next      = r_state;
    bus.avm_read      = 1'b0;
    bus.avm_write     = 1'b0;
    bus.avm_address   = '0;
    bus.avm_writedata = '0;
    bus.req_readdata  = '0;
    bus.req_finished  = '0;
    bus.grant         = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_win_valid) begin
          // When read and write are both set, the write wins.
          w_state_next = bus.req_write[w_win_idx] ? ST_WRITE : ST_READ_CMD;
        end
      end
      ST_WRITE: begin
        bus.grant         = w_gnt_onehot;
        bus.avm_write     = 1'b1;
        bus.avm_address   = r_op_addr;
        bus.avm_writedata = r_op_data;
        if (!bus.avm_waitrequest) begin
          bus.req_finished = w_gnt_onehot;
          w_state_next     = ST_IDLE;
        end
      end
      ST_READ_CMD: begin
        bus.grant       = w_gnt_onehot;
        bus.avm_read    = 1'b1;
        bus.avm_address = r_op_addr;
        if (!bus.avm_waitrequest) begin
          w_state_next = ST_READ_WAIT;
        end
      end
      ST_READ_WAIT: begin
        bus.grant        = w_gnt_onehot;
        bus.avm_address  = r_op_addr;
        bus.req_readdata = bus.avm_readdata;
        if (bus.avm_readdatavalid) begin
          bus.req_finished = w_gnt_onehot;
          w_state_next     = ST_IDLE;
        end else if (w_tmo_hit) begin
          // Abandoned read: complete it with zero data so the requester is not stuck.
          bus.req_readdata = '0;
          bus.req_finished = w_gnt_onehot;
          w_state_next     = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed testbench for sdram_arbiter. Inputs are driven 1 ns after the rising
// edge, and outputs are compared on the falling edge.
module tb_sdram_arbiter;
  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 23;
  localparam int DATA_W  = 32;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  sdram_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sdram_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(15)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Structural invariants, checked on every falling edge outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (!$onehot0(bus.grant) || !$onehot0(bus.req_finished) || (bus.avm_read && bus.avm_write)) begin
        failures++;
        $display("FAIL invariant: grant=%b finished=%b read=%b write=%b (one-hot-or-zero, not both)",
                 bus.grant, bus.req_finished, bus.avm_read, bus.avm_write);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_read          = '0;
    bus.req_write         = '0;
    bus.req_addr          = '0;
    bus.req_writedata     = '0;
    bus.avm_readdata      = '0;
    bus.avm_waitrequest   = 1'b0;
    bus.avm_readdatavalid = 1'b0;
  endtask

  task automatic set_req(input int idx, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.req_addr[idx*ADDR_W +: ADDR_W]      = a;
    bus.req_writedata[idx*DATA_W +: DATA_W] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    bus.req_write    = 3'b111;
    bus.avm_readdata = 32'hCAFE_F00D;
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.grant !== 3'b000 || bus.avm_write !== 1'b0 || bus.avm_read !== 1'b0 ||
        bus.req_finished !== 3'b000 || bus.timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: grant=%b wr=%b rd=%b fin=%b terr=%b required all zero",
               bus.grant, bus.avm_write, bus.avm_read, bus.req_finished, bus.timeout_err);
    end
    next_cycle();
    bus.req_write = '0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.avm_address !== '0 || bus.avm_writedata !== '0 || bus.req_readdata !== '0 || bus.grant !== '0) begin
      failures++;
      $display("FAIL idle_outputs: addr=%h wdata=%h rdata=%h grant=%b required all zero",
               bus.avm_address, bus.avm_writedata, bus.req_readdata, bus.grant);
    end
    $display("tb: reset done");
  endtask

  task automatic test_single_write();
    next_cycle();
    set_req(0, 23'h000010, 32'hDEADBEEF);
    bus.req_write[0]    = 1'b1;
    bus.avm_waitrequest = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.grant !== 3'b000 || bus.avm_write !== 1'b0) begin
      failures++;
      $display("FAIL write_arb_cycle: grant=%b wr=%b required 000/0", bus.grant, bus.avm_write);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.avm_write !== 1'b1 || bus.avm_address !== 23'h000010 || bus.avm_writedata !== 32'hDEADBEEF ||
        bus.req_finished !== 3'b001 || bus.grant !== 3'b001) begin
      failures++;
      $display("FAIL write_cmd: wr=%b addr=%h data=%h fin=%b grant=%b required 1/000010/deadbeef/001/001",
               bus.avm_write, bus.avm_address, bus.avm_writedata, bus.req_finished, bus.grant);
    end
    next_cycle();
    bus.req_write[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.avm_write !== 1'b0 || bus.req_finished !== 3'b000 || bus.grant !== 3'b000) begin
      failures++;
      $display("FAIL write_done_idle: wr=%b fin=%b grant=%b required 0/000/000",
               bus.avm_write, bus.req_finished, bus.grant);
    end
    $display("tb: single write req0 addr=000010 data=deadbeef");
  endtask

  task automatic test_stalled_read();
    next_cycle();
    set_req(1, 23'h7FFFFF, 32'h0);
    bus.req_read[1]     = 1'b1;
    bus.avm_waitrequest = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      if (i == 1) set_req(1, 23'h000001, 32'h0);  // operand change must not reach the bus
      if (i == 3) bus.avm_waitrequest = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.avm_read !== 1'b1 || bus.grant !== 3'b010 || bus.avm_address !== 23'h7FFFFF) begin
        failures++;
        $display("FAIL read_cmd_%0d: rd=%b grant=%b addr=%h required 1/010/7fffff",
                 i, bus.avm_read, bus.grant, bus.avm_address);
      end
    end
    for (int j = 0; j < 4; j++) begin
      next_cycle();
      bus.avm_waitrequest = 1'b1;
      if (j == 3) begin
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = 32'h12345678;
      end
      @(negedge clk);
      checks++;
      if (j < 3) begin
        if (bus.avm_read !== 1'b0 || bus.req_finished !== 3'b000) begin
          failures++;
          $display("FAIL read_wait_%0d: rd=%b fin=%b required 0/000", j, bus.avm_read, bus.req_finished);
        end
      end else begin
        if (bus.req_readdata !== 32'h12345678 || bus.req_finished !== 3'b010) begin
          failures++;
          $display("FAIL read_valid: rdata=%h fin=%b required 12345678/010", bus.req_readdata, bus.req_finished);
        end
      end
    end
    next_cycle();
    bus.req_read[1]       = 1'b0;
    bus.avm_readdatavalid = 1'b0;
    bus.avm_waitrequest   = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_finished !== 3'b000 || bus.grant !== 3'b000) begin
      failures++;
      $display("FAIL read_done_idle: fin=%b grant=%b required 000/000", bus.req_finished, bus.grant);
    end
    $display("tb: stalled read req1 addr=7fffff data=12345678");
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [12];
    exp_g = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100,
              3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100};
    rst = 1'b1;
    next_cycle();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 23'(23'h100 + i), 32'(32'hA000 + i));
    bus.req_write = 3'b111;
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if (bus.grant !== exp_g[c] || bus.req_finished !== exp_g[c]) begin
        failures++;
        $display("FAIL rr_cycle_%0d: grant=%b fin=%b required %b", c, bus.grant, bus.req_finished, exp_g[c]);
      end
      if (exp_g[c] != 3'b000) begin
        checks++;
        if (bus.avm_address !== 23'(23'h100 + (c - 1) / 2 % 3)) begin
          failures++;
          $display("FAIL rr_addr_%0d: addr=%h required %h", c, bus.avm_address, 23'(23'h100 + (c - 1) / 2 % 3));
        end
      end
      $display("tb: round robin cycle %0d grant=%b", c, bus.grant);
      next_cycle();
    end
    bus.req_write = '0;
  endtask

  task automatic test_timeout();
    next_cycle();
    set_req(0, 23'h000ABC, 32'h0);
    bus.req_read[0]       = 1'b1;
    bus.avm_readdata      = 32'hA5A5_5A5A;
    bus.avm_readdatavalid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL tmo_err_initial: terr=%b required 0", bus.timeout_err);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.avm_read !== 1'b1 || bus.grant !== 3'b001) begin
      failures++;
      $display("FAIL tmo_read_cmd: rd=%b grant=%b required 1/001", bus.avm_read, bus.grant);
    end
    for (int i = 1; i <= 16; i++) begin
      next_cycle();
      @(negedge clk);
      checks++;
      if (i < 16) begin
        if (bus.req_finished !== 3'b000 || (i == 1 && bus.req_readdata !== 32'hA5A5_5A5A)) begin
          failures++;
          $display("FAIL tmo_wait_%0d: fin=%b rdata=%h required 000 (passthrough a5a55a5a)",
                   i, bus.req_finished, bus.req_readdata);
        end
      end else begin
        if (bus.req_finished !== 3'b001 || bus.req_readdata !== 32'h0) begin
          failures++;
          $display("FAIL tmo_abort: fin=%b rdata=%h required 001/00000000", bus.req_finished, bus.req_readdata);
        end
      end
    end
    next_cycle();
    bus.req_read[0] = 1'b0;
    bus.avm_readdatavalid = 1'b1;  // late data arriving in IDLE
    @(negedge clk);
    checks++;
    if (bus.timeout_err !== 1'b1 || bus.req_finished !== 3'b000 || bus.grant !== 3'b000) begin
      failures++;
      $display("FAIL tmo_late_valid: terr=%b fin=%b grant=%b required 1/000/000",
               bus.timeout_err, bus.req_finished, bus.grant);
    end
    next_cycle();
    bus.avm_readdatavalid = 1'b0;
    set_req(1, 23'h000055, 32'h55);
    bus.req_write[1] = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.timeout_err !== 1'b1 || bus.req_finished !== 3'b010) begin
      failures++;
      $display("FAIL tmo_sticky: terr=%b fin=%b required 1/010", bus.timeout_err, bus.req_finished);
    end
    next_cycle();
    bus.req_write[1] = 1'b0;
    $display("tb: timeout read req0 aborted after 16 wait cycles");
  endtask

  task automatic test_conflict_reset();
    next_cycle();
    set_req(2, 23'h000222, 32'h2222);
    bus.req_read[2]  = 1'b1;
    bus.req_write[2] = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.avm_write !== 1'b1 || bus.avm_read !== 1'b0 || bus.grant !== 3'b100 || bus.req_finished !== 3'b100) begin
      failures++;
      $display("FAIL conflict_write: wr=%b rd=%b grant=%b fin=%b required 1/0/100/100",
               bus.avm_write, bus.avm_read, bus.grant, bus.req_finished);
    end
    next_cycle();
    bus.req_read[2]  = 1'b0;
    bus.req_write[2] = 1'b0;
    next_cycle();
    set_req(1, 23'h000111, 32'h0);
    bus.req_read[1] = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.grant !== 3'b010 || bus.avm_read !== 1'b0) begin
      failures++;
      $display("FAIL reset_pre_wait: grant=%b rd=%b required 010/0", bus.grant, bus.avm_read);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.avm_read !== 1'b0 || bus.grant !== 3'b000 || bus.req_finished !== 3'b000) begin
      failures++;
      $display("FAIL reset_async: rd=%b grant=%b fin=%b required 0/000/000",
               bus.avm_read, bus.grant, bus.req_finished);
    end
    bus.req_read  = '0;
    bus.req_write = 3'b111;
    next_cycle();
    rst = 1'b0;
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.grant !== 3'b001) begin
      failures++;
      $display("FAIL reset_first_grant: grant=%b required 001", bus.grant);
    end
    next_cycle();
    bus.req_write = '0;
    $display("tb: conflict wrote req2, reset mid-read regranted req0");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    clear_inputs();
    test_reset();
    test_single_write();
    test_stalled_read();
    test_round_robin();
    test_timeout();
    test_conflict_reset();
    next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
